// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide with sign fix-up on completion.
module ex_muldiv #(
  parameter int XLEN    = 32,
  parameter int STEP    = 1,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [XLEN-1:0]    r1_data_i,
  input  logic [XLEN-1:0]    r2_data_i,
  input  logic [RADDR_W-1:0] w_addr_i,
  input  logic               flush_i,
  output logic               stall_req_o,
  output logic               busy_o,
  output logic               valid_o,
  output logic               w_enable_o,
  output logic [RADDR_W-1:0] w_addr_o,
  output logic [XLEN-1:0]    w_data_o
);

  localparam int N  = XLEN / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]         op_q;
  logic [RADDR_W-1:0] waddr_q;
  logic [XLEN-1:0]    opnd_q;
  logic [2*XLEN-1:0]  acc_q;
  logic [2*XLEN-1:0]  acc_step;
  logic [CW-1:0]      cnt_q;
  logic               neg_a_q;
  logic               neg_b_q;

  logic               a_sgn, b_sgn;
  logic               neg_a, neg_b;
  logic [XLEN-1:0]    mag_a, mag_b;
  logic               div_zero, ovf;
  logic [XLEN-1:0]    spec_res;

  logic [XLEN:0]      rem_t, sum_t;
  logic [XLEN-1:0]    quo_t;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    quo, rem;
  logic [XLEN-1:0]    calc_res;

  logic               load, fin;
  logic [XLEN-1:0]    res_d;
  logic [RADDR_W-1:0] addr_d;

  assign a_sgn = op_i[2] ? ~op_i[0]
                         : (op_i[1:0] == 2'b01) | (op_i[1:0] == 2'b10);
  assign b_sgn = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
  assign neg_a = a_sgn & r1_data_i[XLEN-1];
  assign neg_b = b_sgn & r2_data_i[XLEN-1];
  assign mag_a = neg_a ? -r1_data_i : r1_data_i;
  assign mag_b = neg_b ? -r2_data_i : r2_data_i;

  assign div_zero = op_i[2] & ~|r2_data_i;
  assign ovf      = op_i[2] & ~op_i[0] & (r1_data_i == MIN)
                  & (&r2_data_i);

  always_comb begin
    spec_res = '0;
    if (div_zero)
      spec_res = op_i[1] ? r1_data_i : '1;
    else if (ovf)
      spec_res = op_i[1] ? '0 : r1_data_i;
  end

  // acc holds {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    acc_step = acc_q;
    rem_t    = '0;
    quo_t    = '0;
    sum_t    = '0;
    for (int i = 0; i < STEP; i++) begin
      if (op_q[2]) begin
        rem_t = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
        quo_t = {acc_step[XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, opnd_q}) begin
          rem_t    = rem_t - {1'b0, opnd_q};
          quo_t[0] = 1'b1;
        end
        acc_step = {rem_t[XLEN-1:0], quo_t};
      end else begin
        sum_t = {1'b0, acc_step[2*XLEN-1:XLEN]}
              + (acc_step[0] ? {1'b0, opnd_q} : '0);
        acc_step = {sum_t, acc_step[XLEN-1:1]};
      end
    end
  end

  assign prod = (neg_a_q ^ neg_b_q) ? -acc_step : acc_step;
  assign quo  = (neg_a_q ^ neg_b_q) ? -acc_step[XLEN-1:0]
                                    : acc_step[XLEN-1:0];
  assign rem  = neg_a_q ? -acc_step[2*XLEN-1:XLEN]
                        : acc_step[2*XLEN-1:XLEN];

  always_comb begin
    calc_res = '0;
    unique case (1'b1)
      op_q == 3'b000:                 calc_res = prod[XLEN-1:0];
      ~op_q[2] & (|op_q[1:0]):        calc_res = prod[2*XLEN-1:XLEN];
      op_q[2] & ~op_q[1]:             calc_res = quo;
      op_q[2] & op_q[1]:              calc_res = rem;
      default:                        calc_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fin     = 1'b0;
    res_d   = calc_res;
    addr_d  = waddr_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          load   = 1'b1;
          addr_d = w_addr_i;
          if (div_zero || ovf) begin
            state_d = DONE;
            fin     = 1'b1;
            res_d   = spec_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(1)) begin
          state_d = DONE;
          fin     = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o    <= 1'b0;
      w_enable_o <= 1'b0;
      w_addr_o   <= '0;
      w_data_o   <= '0;
      op_q       <= '0;
      waddr_q    <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
    end else begin
      valid_o    <= fin;
      w_enable_o <= fin & (|addr_d);
      if (fin) begin
        w_data_o <= res_d;
        w_addr_o <= addr_d;
      end
      if (load) begin
        op_q    <= op_i;
        waddr_q <= w_addr_i;
        neg_a_q <= neg_a;
        neg_b_q <= neg_b;
        cnt_q   <= CW'(N);
        if (op_i[2]) begin
          opnd_q <= mag_b;
          acc_q  <= {{XLEN{1'b0}}, mag_a};
        end else begin
          opnd_q <= mag_a;
          acc_q  <= {{XLEN{1'b0}}, mag_b};
        end
      end else if (state_q == CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign stall_req_o = ((state_q == IDLE) & start_i & ~flush_i)
                     | (state_q == CALC);

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vectors, flush/reset cases and random ops
// against a 64-bit arithmetic reference model.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] r1_data_i;
  logic [31:0] r2_data_i;
  logic [4:0]  w_addr_i;
  logic        flush_i;
  logic        stall_req_o;
  logic        busy_o;
  logic        valid_o;
  logic        w_enable_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;

  int n_chk = 0;
  int n_pass = 0;

  ex_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .r1_data_i   (r1_data_i),
    .r2_data_i   (r2_data_i),
    .w_addr_i    (w_addr_i),
    .flush_i     (flush_i),
    .stall_req_o (stall_req_o),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .w_enable_o  (w_enable_o),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        r = sa / sb; p = 64'(r); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        r = ua / ub; p = 64'(r); return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        r = sa % sb; p = 64'(r); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        r = ua % ub; p = 64'(r); return p[31:0];
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa);
    int cyc, stl, lat;
    logic [31:0] exp;
    bit sp;
    exp = ref_op(op, a, b);
    sp  = op[2] && (b == 0 ||
          (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    lat = sp ? 1 : 33;
    @(negedge clk);
    start_i   = 1'b1;
    op_i      = op;
    r1_data_i = a;
    r2_data_i = b;
    w_addr_i  = wa;
    #1;
    stl = stall_req_o ? 1 : 0;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (!valid_o && cyc < 100) begin
      if (stall_req_o) stl++;
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("lat op%0d", op), cyc, lat);
    chk($sformatf("stall op%0d", op), stl, lat);
    chk($sformatf("data op%0d %h,%h", op, a, b), w_data_o, exp);
    chk("wen", w_enable_o, (wa != 0));
    chk("waddr", w_addr_o, wa);
    @(negedge clk);
    chk("strobe", valid_o, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int vc;
    rst = 1'b0;
    start_i = 1'b0;
    op_i = '0;
    r1_data_i = '0;
    r2_data_i = '0;
    w_addr_i = '0;
    flush_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst valid", valid_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst data", w_data_o, 0);
    chk("rst waddr", w_addr_o, 0);
    chk("rst stall", stall_req_o, 0);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 5'd3);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6);
    run_op(3'd5, 32'd100, 32'd7, 5'd7);
    run_op(3'd7, 32'd100, 32'd7, 5'd8);
    run_op(3'd5, 32'd5, 32'd0, 5'd9);
    run_op(3'd6, 32'd5, 32'd0, 5'd10);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11);
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12);
    run_op(3'd0, 32'd9, 32'd9, 5'd0);

    // start together with flush is refused
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0;
    #1;
    chk("flush+start stall", stall_req_o, 0);
    @(negedge clk);
    chk("flush+start busy", busy_o, 0);
    start_i = 1'b0; flush_i = 1'b0;

    // flush mid-CALC
    start_i = 1'b1; op_i = 3'd0; r1_data_i = 5; r2_data_i = 6;
    w_addr_i = 5'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush busy", busy_o, 0);
    vc = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) vc++;
    end
    chk("flush noval", vc, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd7);

    // reset mid-CALC
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; r1_data_i = 1000; r2_data_i = 3;
    w_addr_i = 5'd9;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst busy", busy_o, 0);
    chk("mrst stall", stall_req_o, 0);
    chk("mrst data", w_data_o, 0);
    chk("mrst waddr", w_addr_o, 0);
    chk("mrst wen", w_enable_o, 0);
    @(negedge clk);
    rst = 1'b1;
    vc = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o || busy_o || stall_req_o) vc++;
    end
    chk("mrst idle", vc, 0);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(),
             5'($urandom_range(0, 31)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
